// File: rtl/mem_bus_arbiter_if.sv
// Shared SRAM bus bundle: two requester ports plus the registered SRAM side.
// The arbiter takes the slave view; a bench or SoC wrapper takes the master view.
interface mem_bus_arbiter_if #(
  parameter int AW = 20,
  parameter int DW = 8
);
  logic          a_req;
  logic          a_we;
  logic [AW-1:0] a_address;
  logic [DW-1:0] a_o_data;
  logic          a_gnt;
  logic [DW-1:0] a_i_data;
  logic          a_rvalid;

  logic          b_req;
  logic [AW-1:0] b_address;
  logic          b_gnt;
  logic [DW-1:0] b_i_data;
  logic          b_rvalid;

  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_o_data;
  logic          mem_we;
  logic [DW-1:0] mem_i_data;

  modport slave (
    input  a_req, a_we, a_address, a_o_data,
    input  b_req, b_address,
    input  mem_i_data,
    output a_gnt, a_i_data, a_rvalid,
    output b_gnt, b_i_data, b_rvalid,
    output mem_address, mem_o_data, mem_we
  );

  modport master (
    output a_req, a_we, a_address, a_o_data,
    output b_req, b_address,
    output mem_i_data,
    input  a_gnt, a_i_data, a_rvalid,
    input  b_gnt, b_i_data, b_rvalid,
    input  mem_address, mem_o_data, mem_we
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-port arbiter for a byte-wide synchronous SRAM: B (read-only, real-time) has
// priority, a burst limiter forces A through, reads return two edges after issue.
module mem_bus_arbiter #(
  parameter int AW          = 20,
  parameter int DW          = 8,
  parameter int B_MAX_BURST = 4
) (
  input logic              clock,
  input logic              reset,
  mem_bus_arbiter_if.slave bus
);

  localparam logic [3:0] MaxBurst = 4'(B_MAX_BURST);

  logic [3:0]    burstCnt_q, burstCnt_d;
  logic          burstFull;
  logic          aGnt, bGnt;

  logic [AW-1:0] memAddress_q;
  logic [DW-1:0] memOData_q;
  logic          memWe_q;

  logic          tag0Valid_q, tag0Port_q;
  logic          tag1Valid_q, tag1Port_q;

  logic [DW-1:0] aIData_q, bIData_q;
  logic          aRvalid_q, bRvalid_q;

  assign burstFull = (burstCnt_q == MaxBurst);

  // B wins unless A is waiting and B has used up its burst allowance.
  assign bGnt = !reset && bus.b_req && !(bus.a_req && burstFull);
  assign aGnt = !reset && bus.a_req && (!bus.b_req || burstFull);

  always_comb begin
    burstCnt_d = burstCnt_q;
    if (!bus.a_req || aGnt) begin
      burstCnt_d = 4'd0;
    end else if (bGnt && !burstFull) begin
      burstCnt_d = burstCnt_q + 4'd1;
    end
  end

  // Tag port bit: 1 = B, 0 = A. Data is captured when a tag leaves stage 1.
  always_ff @(posedge clock) begin
    if (reset) begin
      burstCnt_q   <= 4'd0;
      memAddress_q <= '0;
      memOData_q   <= '0;
      memWe_q      <= 1'b0;
      tag0Valid_q  <= 1'b0;
      tag0Port_q   <= 1'b0;
      tag1Valid_q  <= 1'b0;
      tag1Port_q   <= 1'b0;
      aIData_q     <= '0;
      bIData_q     <= '0;
      aRvalid_q    <= 1'b0;
      bRvalid_q    <= 1'b0;
    end else begin
      burstCnt_q <= burstCnt_d;
      memWe_q    <= aGnt && bus.a_we;
      if (aGnt) begin
        memAddress_q <= bus.a_address;
      end else if (bGnt) begin
        memAddress_q <= bus.b_address;
      end
      if (aGnt && bus.a_we) begin
        memOData_q <= bus.a_o_data;
      end

      tag0Valid_q <= bGnt || (aGnt && !bus.a_we);
      tag0Port_q  <= bGnt;
      tag1Valid_q <= tag0Valid_q;
      tag1Port_q  <= tag0Port_q;

      aRvalid_q <= tag1Valid_q && !tag1Port_q;
      bRvalid_q <= tag1Valid_q && tag1Port_q;
      if (tag1Valid_q && !tag1Port_q) begin
        aIData_q <= bus.mem_i_data;
      end
      if (tag1Valid_q && tag1Port_q) begin
        bIData_q <= bus.mem_i_data;
      end
    end
  end

  assign bus.a_gnt       = aGnt;
  assign bus.b_gnt       = bGnt;
  assign bus.mem_address = memAddress_q;
  assign bus.mem_o_data  = memOData_q;
  assign bus.mem_we      = memWe_q;
  assign bus.a_i_data    = aIData_q;
  assign bus.a_rvalid    = aRvalid_q;
  assign bus.b_i_data    = bIData_q;
  assign bus.b_rvalid    = bRvalid_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with a write-first synchronous SRAM model
// and a read-return monitor recording every rvalid pulse.
module tb_mem_bus_arbiter;

  localparam int AW = 20;
  localparam int DW = 8;

  logic clock = 1'b0;
  logic reset = 1'b1;

  always #20 clock = ~clock;

  mem_bus_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  mem_bus_arbiter #(.AW(AW), .DW(DW), .B_MAX_BURST(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  int cycleCnt = 0;

  typedef struct {
    int         cyc;
    bit         port;
    logic [7:0] data;
  } rdEvent_t;

  typedef struct {
    bit         port;
    logic [7:0] data;
  } expRd_t;

  rdEvent_t rdQ[$];
  expRd_t   expQ[$];

  logic [7:0] sram [logic [19:0]];

  // Background SRAM contents for locations never written.
  function automatic logic [7:0] pat(input logic [19:0] a);
    return (a[7:0] * 8'd7) ^ a[15:8] ^ {a[19:16], 4'hC};
  endfunction

  function automatic logic [7:0] sramRead(input logic [19:0] a);
    if (sram.exists(a)) return sram[a];
    return pat(a);
  endfunction

  // Synchronous SRAM, write-first: data for the presented address appears next cycle.
  always @(posedge clock) begin
    cycleCnt++;
    if (!$isunknown(bus.mem_address)) begin
      if (bus.mem_we === 1'b1) begin
        sram[bus.mem_address] = bus.mem_o_data;
        bus.mem_i_data <= bus.mem_o_data;
      end else begin
        bus.mem_i_data <= sramRead(bus.mem_address);
      end
    end
  end

  always @(negedge clock) begin
    if (bus.a_rvalid === 1'b1) rdQ.push_back('{cycleCnt, 1'b0, bus.a_i_data});
    if (bus.b_rvalid === 1'b1) rdQ.push_back('{cycleCnt, 1'b1, bus.b_i_data});
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic aReq, input logic aWe, input logic [19:0] aAddr,
                               input logic [7:0] aData, input logic bReq, input logic [19:0] bAddr);
    bus.a_req     = aReq;
    bus.a_we      = aWe;
    bus.a_address = aAddr;
    bus.a_o_data  = aData;
    bus.b_req     = bReq;
    bus.b_address = bAddr;
    #1;
  endtask

  task automatic stepCycle();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic idleCycles(input int n);
    applyStimulus(1'b0, 1'b0, 20'h0, 8'h0, 1'b0, 20'h0);
    for (int i = 0; i < n; i++) stepCycle();
  endtask

  initial begin
    logic [19:0] aAddr;
    logic [19:0] bAddr;
    logic [7:0]  gotCh;
    logic [7:0]  expCh;
    string       grantSeq;

    // Reset with both requesters pushing.
    reset = 1'b1;
    applyStimulus(1'b1, 1'b0, 20'h11111, 8'h55, 1'b1, 20'h22222);
    stepCycle();
    #1;
    checkOutput("rst_a_gnt", bus.a_gnt, 0);
    checkOutput("rst_b_gnt", bus.b_gnt, 0);
    checkOutput("rst_mem_we", bus.mem_we, 0);
    checkOutput("rst_mem_address", bus.mem_address, 0);
    checkOutput("rst_mem_o_data", bus.mem_o_data, 0);
    checkOutput("rst_a_rvalid", bus.a_rvalid, 0);
    checkOutput("rst_b_rvalid", bus.b_rvalid, 0);
    checkOutput("rst_a_i_data", bus.a_i_data, 0);
    checkOutput("rst_b_i_data", bus.b_i_data, 0);
    stepCycle();
    checkOutput("rst2_a_gnt", bus.a_gnt, 0);
    checkOutput("rst2_b_gnt", bus.b_gnt, 0);
    checkOutput("rst2_mem_we", bus.mem_we, 0);
    reset = 1'b0;
    idleCycles(2);

    // Single A read.
    sram[20'h12345] = 8'hA5;
    rdQ.delete();
    applyStimulus(1'b1, 1'b0, 20'h12345, 8'h00, 1'b0, 20'h0);
    checkOutput("rd_a_gnt", bus.a_gnt, 1);
    checkOutput("rd_b_gnt", bus.b_gnt, 0);
    stepCycle();
    checkOutput("rd_mem_address", bus.mem_address, 32'h12345);
    checkOutput("rd_mem_we", bus.mem_we, 0);
    applyStimulus(1'b0, 1'b0, 20'h0, 8'h0, 1'b0, 20'h0);
    checkOutput("rd_idle_a_gnt", bus.a_gnt, 0);
    stepCycle();
    checkOutput("rd_rvalid_early", bus.a_rvalid, 0);
    stepCycle();
    checkOutput("rd_rvalid", bus.a_rvalid, 1);
    checkOutput("rd_data", bus.a_i_data, 32'hA5);
    stepCycle();
    checkOutput("rd_rvalid_pulse", bus.a_rvalid, 0);
    checkOutput("rd_data_hold", bus.a_i_data, 32'hA5);
    checkOutput("rd_count", rdQ.size(), 1);

    // A write then immediate read of the same address.
    rdQ.delete();
    applyStimulus(1'b1, 1'b1, 20'h0FFFF, 8'h3C, 1'b0, 20'h0);
    checkOutput("wr_a_gnt", bus.a_gnt, 1);
    stepCycle();
    checkOutput("wr_mem_we", bus.mem_we, 1);
    checkOutput("wr_mem_o_data", bus.mem_o_data, 32'h3C);
    checkOutput("wr_mem_address", bus.mem_address, 32'h0FFFF);
    applyStimulus(1'b1, 1'b0, 20'h0FFFF, 8'h00, 1'b0, 20'h0);
    checkOutput("wrrd_a_gnt", bus.a_gnt, 1);
    stepCycle();
    checkOutput("wr_mem_we_one", bus.mem_we, 0);
    applyStimulus(1'b0, 1'b0, 20'h0, 8'h0, 1'b0, 20'h0);
    stepCycle();
    checkOutput("wr_no_rvalid", bus.a_rvalid, 0);
    stepCycle();
    checkOutput("wrrd_rvalid", bus.a_rvalid, 1);
    checkOutput("wrrd_data", bus.a_i_data, 32'h3C);
    idleCycles(2);
    checkOutput("wrrd_count", rdQ.size(), 1);

    // Contention: both ports requesting, B limited to four in a row.
    rdQ.delete();
    expQ.delete();
    grantSeq = "BBBBABBBBA";
    aAddr = 20'h20000;
    bAddr = 20'h00000;
    begin
      logic [19:0] expA = 20'h20000;
      logic [19:0] expB = 20'h00000;
      for (int i = 0; i < 10; i++) begin
        expCh = grantSeq[i];
        if (expCh == "B") begin
          expQ.push_back('{1'b1, sramRead(expB)});
          expB++;
        end else begin
          expQ.push_back('{1'b0, sramRead(expA)});
          expA++;
        end
      end
    end
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 1'b0, aAddr, 8'h00, 1'b1, bAddr);
      gotCh = "-";
      if (bus.a_gnt && bus.b_gnt) gotCh = "2";
      else if (bus.a_gnt) gotCh = "A";
      else if (bus.b_gnt) gotCh = "B";
      expCh = grantSeq[i];
      checkOutput($sformatf("grant%0d", i), gotCh, expCh);
      if (bus.a_gnt) aAddr++;
      else if (bus.b_gnt) bAddr++;
      stepCycle();
    end
    idleCycles(4);
    checkOutput("contend_count", rdQ.size(), 10);
    for (int i = 0; i < 10; i++) begin
      if (i < rdQ.size()) begin
        checkOutput($sformatf("contend_port%0d", i), rdQ[i].port, expQ[i].port);
        checkOutput($sformatf("contend_data%0d", i), rdQ[i].data, expQ[i].data);
        checkOutput($sformatf("contend_cyc%0d", i), rdQ[i].cyc, rdQ[0].cyc + i);
      end
    end

    // Back-to-back B reads.
    rdQ.delete();
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 1'b0, 20'h0, 8'h0, 1'b1, 20'hB8000 + 20'(i));
      checkOutput($sformatf("b2b_gnt%0d", i), bus.b_gnt, 1);
      stepCycle();
    end
    idleCycles(4);
    checkOutput("b2b_count", rdQ.size(), 8);
    for (int i = 0; i < 8; i++) begin
      if (i < rdQ.size()) begin
        checkOutput($sformatf("b2b_port%0d", i), rdQ[i].port, 1);
        checkOutput($sformatf("b2b_data%0d", i), rdQ[i].data, sramRead(20'hB8000 + 20'(i)));
        checkOutput($sformatf("b2b_cyc%0d", i), rdQ[i].cyc, rdQ[0].cyc + i);
      end
    end

    // Idle hold after a write.
    applyStimulus(1'b1, 1'b1, 20'h00100, 8'hE7, 1'b0, 20'h0);
    stepCycle();
    checkOutput("idle_wr_we", bus.mem_we, 1);
    applyStimulus(1'b0, 1'b0, 20'h0, 8'h0, 1'b0, 20'h0);
    for (int i = 0; i < 5; i++) begin
      stepCycle();
      checkOutput($sformatf("idle_we%0d", i), bus.mem_we, 0);
      checkOutput($sformatf("idle_addr%0d", i), bus.mem_address, 32'h00100);
    end
    checkOutput("idle_o_data", bus.mem_o_data, 32'hE7);

    // Reset one cycle after an A read transfer discards the read.
    rdQ.delete();
    applyStimulus(1'b1, 1'b0, 20'h54321, 8'h00, 1'b0, 20'h0);
    checkOutput("mrst_a_gnt", bus.a_gnt, 1);
    stepCycle();
    reset = 1'b1;
    applyStimulus(1'b1, 1'b0, 20'h54322, 8'h00, 1'b1, 20'h00010);
    checkOutput("mrst_gnt_a_off", bus.a_gnt, 0);
    checkOutput("mrst_gnt_b_off", bus.b_gnt, 0);
    stepCycle();
    checkOutput("mrst_mem_we", bus.mem_we, 0);
    checkOutput("mrst_mem_address", bus.mem_address, 0);
    checkOutput("mrst_a_i_data", bus.a_i_data, 0);
    reset = 1'b0;
    idleCycles(4);
    checkOutput("mrst_no_rvalid", rdQ.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
